// File: rtl/psum_acc_mux.sv
// psum_acc_mux: receiving end of the MAC->MUX partial-sum interface.
// Round-robin arbitrates the MAC psum streams, accumulates accepted psums
// into a flop-based row buffer with signed saturation, and drains the
// finished row over a valid/ready stream.
module psum_acc_mux #(
   parameter int NUM_MAC         = 3,
   parameter int PSUM_WIDTH      = 24,
   parameter int PSUM_ADDR_WIDTH = 5,
   parameter int ROW_DEPTH       = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_MAC-1:0]                 MACMUX_Val,
   input  logic [NUM_MAC*PSUM_ADDR_WIDTH-1:0] MACMUX_Addr,
   input  logic [NUM_MAC*PSUM_WIDTH-1:0]      MACMUX_Psum,
   output logic [NUM_MAC-1:0]                 MACMUX_Rdy,
   input  logic                               ARBACC_Clr,
   input  logic                               ARBACC_Drain,
   output logic                               ACCOUT_Val,
   output logic [PSUM_ADDR_WIDTH-1:0]         ACCOUT_Addr,
   output logic [PSUM_WIDTH-1:0]              ACCOUT_Psum,
   input  logic                               ACCOUT_Rdy,
   output logic                               ACCARB_Busy,
   output logic                               ACCARB_DrainDone
);

   localparam int PW    = PSUM_WIDTH;
   localparam int AW    = PSUM_ADDR_WIDTH;
   localparam int IDX_W = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
   localparam int PTR_W = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;

   localparam logic [AW:0]       DEPTH_W   = (AW+1)'(ROW_DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ROW_DEPTH - 1);
   localparam logic [PTR_W-1:0]  LAST_MAC  = PTR_W'(NUM_MAC - 1);
   localparam logic [PW-1:0]     SAT_MAX   = {1'b0, {(PW-1){1'b1}}};
   localparam logic [PW-1:0]     SAT_MIN   = {1'b1, {(PW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_reg;
   logic [PTR_W-1:0]  rr_ptr_reg;
   logic [IDX_W-1:0]  dptr_reg;
   logic              drain_done_reg;

   logic [AW-1:0]     mac_addr [NUM_MAC];
   logic [PW-1:0]     mac_psum [NUM_MAC];
   logic [PW-1:0]     row_vals [ROW_DEPTH];

   logic              grant_vld;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  grant_next;
   logic              acc_fire;
   logic              acc_write;
   logic              drain_fire;
   logic              in_range;
   logic [AW-1:0]     acc_addr;
   logic [PW-1:0]     acc_psum;
   logic [IDX_W-1:0]  acc_idx;
   logic [PW-1:0]     acc_cur;
   logic [PW:0]       sum_wide;
   logic [PW-1:0]     sat_sum;

   // Unpack the per-MAC address/psum lanes
   for (genvar gi = 0; gi < NUM_MAC; gi++) begin : g_unpack
      assign mac_addr[gi] = MACMUX_Addr[gi*AW +: AW];
      assign mac_psum[gi] = MACMUX_Psum[gi*PW +: PW];
   end

   // Round-robin grant: first requester at or after rr_ptr, wrapping
   always_comb begin
      int               cand_i;
      logic [PTR_W-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_i    = 0;
      cand      = '0;
      for (int k = 0; k < NUM_MAC; k++) begin
         cand_i = int'(rr_ptr_reg) + k;
         if (cand_i >= NUM_MAC) begin
            cand_i = cand_i - NUM_MAC;
         end
         cand = PTR_W'(cand_i);
         if (!grant_vld && MACMUX_Val[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign grant_next = (grant_idx == LAST_MAC) ? '0 : grant_idx + 1'b1;
   assign acc_fire   = (state_reg == ST_ACC) && grant_vld;
   assign drain_fire = (state_reg == ST_DRAIN) && ACCOUT_Rdy;

   // Ready is only ever offered to the granted MAC, and only while accumulating
   always_comb begin
      MACMUX_Rdy = '0;
      if (acc_fire) begin
         MACMUX_Rdy[grant_idx] = 1'b1;
      end
   end

   // Granted operand, range check and saturating signed add
   assign acc_addr = mac_addr[grant_idx];
   assign acc_psum = mac_psum[grant_idx];
   assign acc_idx  = acc_addr[IDX_W-1:0];
   assign in_range = ~acc_addr[AW-1] && ({1'b0, acc_addr} < DEPTH_W);
   assign acc_cur  = row_vals[acc_idx];
   assign sum_wide = {acc_cur[PW-1], acc_cur} + {acc_psum[PW-1], acc_psum};
   assign sat_sum  = (sum_wide[PW] != sum_wide[PW-1]) ?
                     (sum_wide[PW] ? SAT_MIN : SAT_MAX) : sum_wide[PW-1:0];

   // Out-of-range psums complete the handshake but never touch the buffer;
   // a clear in the same cycle discards the transfer.
   assign acc_write = acc_fire && in_range && !ARBACC_Clr;

   // Row buffer: one register per entry, cleared by Clr or as it drains
   for (genvar gi = 0; gi < ROW_DEPTH; gi++) begin : g_row
      logic [PW-1:0] entry_reg;

      // Entry update: clear has priority, then accumulate, then drain-zero
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry_reg <= '0;
         end else if (ARBACC_Clr) begin
            entry_reg <= '0;
         end else if (acc_write && (acc_idx == IDX_W'(gi))) begin
            entry_reg <= sat_sum;
         end else if (drain_fire && (dptr_reg == IDX_W'(gi))) begin
            entry_reg <= '0;
         end
      end

      assign row_vals[gi] = entry_reg;
   end

   // Control FSM: IDLE/ACC/DRAIN with round-robin pointer and drain pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         rr_ptr_reg     <= '0;
         dptr_reg       <= '0;
         drain_done_reg <= 1'b0;
      end else begin
         drain_done_reg <= 1'b0;
         if (ARBACC_Clr) begin
            state_reg  <= ST_ACC;
            rr_ptr_reg <= '0;
            dptr_reg   <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (ARBACC_Drain) begin
                     state_reg <= ST_DRAIN;
                     dptr_reg  <= '0;
                  end
               end
               ST_ACC: begin
                  if (acc_fire) begin
                     rr_ptr_reg <= grant_next;
                  end
                  if (ARBACC_Drain) begin
                     state_reg <= ST_DRAIN;
                     dptr_reg  <= '0;
                  end
               end
               ST_DRAIN: begin
                  if (ACCOUT_Rdy) begin
                     if (dptr_reg == LAST_IDX) begin
                        dptr_reg       <= '0;
                        state_reg      <= ST_IDLE;
                        drain_done_reg <= 1'b1;
                     end else begin
                        dptr_reg <= dptr_reg + 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ACCOUT_Val       = (state_reg == ST_DRAIN);
   assign ACCARB_Busy      = (state_reg == ST_DRAIN);
   assign ACCOUT_Addr      = AW'(dptr_reg);
   assign ACCOUT_Psum      = ACCOUT_Val ? row_vals[dptr_reg] : '0;
   assign ACCARB_DrainDone = drain_done_reg;

endmodule

// File: tb/tb_psum_acc_mux.sv
// tb_psum_acc_mux: directed and random stimulus against a behavioural model
// of the arbiter/accumulator/drain behaviour.
module tb_psum_acc_mux;

   localparam int NM = 3;
   localparam int PW = 24;
   localparam int AW = 5;
   localparam int RD = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NM-1:0]       MACMUX_Val;
   logic [NM*AW-1:0]    MACMUX_Addr;
   logic [NM*PW-1:0]    MACMUX_Psum;
   logic [NM-1:0]       MACMUX_Rdy;
   logic                ARBACC_Clr;
   logic                ARBACC_Drain;
   logic                ACCOUT_Val;
   logic [AW-1:0]       ACCOUT_Addr;
   logic [PW-1:0]       ACCOUT_Psum;
   logic                ACCOUT_Rdy;
   logic                ACCARB_Busy;
   logic                ACCARB_DrainDone;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int        mbuf [RD];
   int        mrr;
   int        mmode;      // 0 idle, 1 accumulating, 2 draining
   logic [2:0] rdy_seen;

   psum_acc_mux #(
      .NUM_MAC(NM), .PSUM_WIDTH(PW), .PSUM_ADDR_WIDTH(AW), .ROW_DEPTH(RD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .MACMUX_Val(MACMUX_Val), .MACMUX_Addr(MACMUX_Addr),
      .MACMUX_Psum(MACMUX_Psum), .MACMUX_Rdy(MACMUX_Rdy),
      .ARBACC_Clr(ARBACC_Clr), .ARBACC_Drain(ARBACC_Drain),
      .ACCOUT_Val(ACCOUT_Val), .ACCOUT_Addr(ACCOUT_Addr),
      .ACCOUT_Psum(ACCOUT_Psum), .ACCOUT_Rdy(ACCOUT_Rdy),
      .ACCARB_Busy(ACCARB_Busy), .ACCARB_DrainDone(ACCARB_DrainDone)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] p24(input int v);
      logic [PW-1:0] t;
      t = v[PW-1:0];
      return 64'(t);
   endfunction

   function automatic int sat24(input longint v);
      if (v > 64'sd8388607)  return 8388607;
      if (v < -64'sd8388608) return -8388608;
      return int'(v);
   endfunction

   function automatic int exp_grant(input logic [2:0] v);
      for (int k = 0; k < NM; k++) begin
         int c;
         c = (mrr + k) % NM;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < RD; i++) mbuf[i] = 0;
      mrr = 0;
   endtask

   // One accumulate-side cycle: drive, check ready, clock, update model
   task automatic mac_cycle(input logic [2:0] val, input logic [NM*AW-1:0] addrs,
                            input logic [NM*PW-1:0] psums, input logic clr, input logic drn);
      int g;
      logic [2:0] exp_rdy;
      logic signed [AW-1:0] sa;
      logic signed [PW-1:0] sp;
      int ai;
      MACMUX_Val   = val;
      MACMUX_Addr  = addrs;
      MACMUX_Psum  = psums;
      ARBACC_Clr   = clr;
      ARBACC_Drain = drn;
      #1;
      g = (mmode == 1) ? exp_grant(val) : -1;
      exp_rdy = 3'b000;
      if (g >= 0) exp_rdy[g] = 1'b1;
      rdy_seen = MACMUX_Rdy;
      check("mac_rdy", MACMUX_Rdy, exp_rdy);
      @(posedge clk);
      #1;
      if (clr) begin
         model_clear();
         mmode = 1;
      end else begin
         if (mmode == 1 && g >= 0) begin
            sa = addrs[g*AW +: AW];
            sp = psums[g*PW +: PW];
            ai = int'(sa);
            if (ai >= 0 && ai < RD) mbuf[ai] = sat24(longint'(mbuf[ai]) + longint'(sp));
            mrr = (g + 1) % NM;
         end
         if (drn && mmode != 2) mmode = 2;
      end
      MACMUX_Val   = '0;
      ARBACC_Clr   = 1'b0;
      ARBACC_Drain = 1'b0;
   endtask

   task automatic rand_mac(input logic drn);
      logic [NM*AW-1:0] a;
      logic [NM*PW-1:0] p;
      logic [PW-1:0] x;
      for (int i = 0; i < NM; i++) begin
         a[i*AW +: AW] = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       x = 24'h7FFFFF - 24'($urandom_range(0, 15));
            1:       x = 24'h800000 + 24'($urandom_range(0, 15));
            default: x = 24'($urandom_range(0, 2000)) - 24'd1000;
         endcase
         p[i*PW +: PW] = x;
      end
      mac_cycle(3'($urandom), a, p, 1'b0, drn);
   endtask

   // Drain the whole row; rdy_mode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
   task automatic run_drain(input int rdy_mode, input bit drain_noise);
      int idx;
      int cyc;
      logic r;
      idx = 0;
      cyc = 0;
      check("busy_start", ACCARB_Busy, 1);
      while (idx < RD && cyc < 400) begin
         case (rdy_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = ($urandom_range(0, 2) != 0);
         endcase
         ACCOUT_Rdy   = r;
         ARBACC_Drain = (drain_noise && idx < 8) ? 1'($urandom) : 1'b0;
         #1;
         check("drain_val", ACCOUT_Val, 1);
         check("drain_addr", ACCOUT_Addr, idx);
         check("drain_psum", ACCOUT_Psum, p24(mbuf[idx]));
         @(posedge clk);
         #1;
         if (r) begin
            mbuf[idx] = 0;
            idx++;
         end
         cyc++;
      end
      ACCOUT_Rdy   = 1'b0;
      ARBACC_Drain = 1'b0;
      check("drain_budget", idx, RD);
      check("drain_done_pulse", ACCARB_DrainDone, 1);
      check("drain_end_val", ACCOUT_Val, 0);
      check("drain_end_busy", ACCARB_Busy, 0);
      mmode = 0;
      @(posedge clk);
      #1;
      check("drain_done_single", ACCARB_DrainDone, 0);
   endtask

   task automatic start_drain();
      mac_cycle(3'b000, '0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      int idx;
      rst_n        = 1'b0;
      MACMUX_Val   = 3'b111;
      MACMUX_Addr  = '0;
      MACMUX_Psum  = '0;
      ARBACC_Clr   = 1'b0;
      ARBACC_Drain = 1'b0;
      ACCOUT_Rdy   = 1'b0;
      rdy_seen     = '0;
      model_clear();
      mmode = 0;

      // Reset values
      #12;
      check("rst_rdy", MACMUX_Rdy, 0);
      check("rst_val", ACCOUT_Val, 0);
      check("rst_addr", ACCOUT_Addr, 0);
      check("rst_psum", ACCOUT_Psum, 0);
      check("rst_busy", ACCARB_Busy, 0);
      check("rst_done", ACCARB_DrainDone, 0);
      @(negedge clk);
      rst_n      = 1'b1;
      MACMUX_Val = '0;
      @(posedge clk);
      #1;

      // IDLE: no ready even with requests
      mac_cycle(3'b111, '0, {24'd1, 24'd1, 24'd1}, 1'b0, 1'b0);

      // Basic accumulate
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      mac_cycle(3'b001, {5'd0, 5'd0, 5'd3}, {24'd0, 24'd0, 24'd5}, 1'b0, 1'b0);
      mac_cycle(3'b001, {5'd0, 5'd0, 5'd3}, {24'd0, 24'd0, 24'hFFFFFE}, 1'b0, 1'b0);
      start_drain();
      run_drain(0, 1'b0);

      // Round-robin fairness
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         mac_cycle(3'b111, '0, {24'd1, 24'd1, 24'd1}, 1'b0, 1'b0);
         check("rr_order", rdy_seen, 3'b001 << (i % 3));
      end
      start_drain();
      run_drain(0, 1'b0);

      // Out-of-range addresses from MAC2
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      mac_cycle(3'b100, {5'h1F, 5'd0, 5'd0}, {24'd100, 24'd0, 24'd0}, 1'b0, 1'b0);
      mac_cycle(3'b100, {5'h10, 5'd0, 5'd0}, {24'd100, 24'd0, 24'd0}, 1'b0, 1'b0);
      start_drain();
      run_drain(0, 1'b0);

      // Saturation, both directions
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      mac_cycle(3'b011, {5'd0, 5'd5, 5'd5}, {24'd0, 24'h7FFFFF, 24'h7FFFFF}, 1'b0, 1'b0);
      mac_cycle(3'b011, {5'd0, 5'd5, 5'd5}, {24'd0, 24'h7FFFFF, 24'h7FFFFF}, 1'b0, 1'b0);
      mac_cycle(3'b110, {5'd6, 5'd6, 5'd0}, {24'h800000, 24'h800000, 24'd0}, 1'b0, 1'b0);
      mac_cycle(3'b110, {5'd6, 5'd6, 5'd0}, {24'h800000, 24'h800000, 24'd0}, 1'b0, 1'b0);
      start_drain();
      run_drain(0, 1'b0);

      // Backpressure with ignored drain requests, then re-drain from IDLE
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) rand_mac(1'b0);
      start_drain();
      run_drain(1, 1'b1);
      start_drain();
      run_drain(0, 1'b0);

      // Clear mid-drain at dptr 7
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) rand_mac(1'b0);
      start_drain();
      idx = 0;
      for (int i = 0; i < 7; i++) begin
         ACCOUT_Rdy = 1'b1;
         #1;
         check("pre_clr_addr", ACCOUT_Addr, idx);
         check("pre_clr_psum", ACCOUT_Psum, p24(mbuf[idx]));
         @(posedge clk);
         #1;
         mbuf[idx] = 0;
         idx++;
      end
      ARBACC_Clr = 1'b1;
      ACCOUT_Rdy = 1'b1;
      #1;
      check("clr_at_addr", ACCOUT_Addr, 7);
      @(posedge clk);
      #1;
      ARBACC_Clr = 1'b0;
      ACCOUT_Rdy = 1'b0;
      model_clear();
      mmode = 1;
      check("clr_busy", ACCARB_Busy, 0);
      check("clr_val", ACCOUT_Val, 0);
      check("clr_no_done", ACCARB_DrainDone, 0);
      @(posedge clk);
      #1;
      check("clr_no_done_late", ACCARB_DrainDone, 0);
      start_drain();
      run_drain(0, 1'b0);

      // Clear together with a transfer discards the psum and resets rr_ptr
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      mac_cycle(3'b010, {5'd0, 5'd2, 5'd0}, {24'd0, 24'd50, 24'd0}, 1'b0, 1'b0);
      mac_cycle(3'b001, {5'd0, 5'd0, 5'd4}, {24'd0, 24'd0, 24'd77}, 1'b1, 1'b0);
      mac_cycle(3'b110, {5'd9, 5'd9, 5'd0}, {24'd4, 24'd3, 24'd0}, 1'b0, 1'b0);
      check("clr_rr_restart", rdy_seen, 3'b010);
      start_drain();
      run_drain(0, 1'b0);

      // Async reset mid-drain
      mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) rand_mac(1'b0);
      start_drain();
      ACCOUT_Rdy = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      ACCOUT_Rdy = 1'b0;
      model_clear();
      mmode = 0;
      check("arst_val", ACCOUT_Val, 0);
      check("arst_busy", ACCARB_Busy, 0);
      check("arst_addr", ACCOUT_Addr, 0);
      check("arst_psum", ACCOUT_Psum, 0);
      check("arst_done", ACCARB_DrainDone, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_no_resume", ACCARB_Busy, 0);
      start_drain();
      run_drain(0, 1'b0);

      // Random rounds, drain requested together with a random transfer
      for (int r = 0; r < 6; r++) begin
         mac_cycle(3'b000, '0, '0, 1'b1, 1'b0);
         for (int n = 0; n < 30; n++) rand_mac(1'b0);
         rand_mac(1'b1);
         run_drain(2, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
